pdp_read_agent: RTL

PDP_READ_AGENT -- requirements
Module: pdp_read_agent

---
 rtl/pdp_pkg.sv | 21 ++
 rtl/pdp_rsp_fifo.sv | 51 +++++
 rtl/pdp_read_agent.sv | 99 +++++++++
 3 files changed

// File: rtl/pdp_pkg.sv
// Shared constants and elaboration helpers for the PDP RAM read/write agents.
package pdp_pkg;

    localparam string PDP_REGMODE_REG   = "reg";
    localparam string PDP_REGMODE_NOREG = "noreg";

    // Edges from address capture to sampled read data; the output register adds one.
    function automatic int pdp_latency(input bit noreg);
        return noreg ? 1 : 2;
    endfunction

    function automatic int pdp_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pdp_rsp_fifo.sv
// Response buffer for the read agent: synchronous FIFO, power-of-two depth,
// pointers wrap naturally and the count carries one extra bit to tell full from empty.
module pdp_rsp_fifo
    import pdp_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4,
    localparam int PTR_W = pdp_clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    assign count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/pdp_read_agent.sv
// Read-side agent for a pseudo-dual-port RAM: issues reads on a credit basis,
// tracks them through the RAM pipeline and returns data plus ECC flags in order.
module pdp_read_agent
    import pdp_pkg::*;
#(
    parameter int    RADDR_WIDTH = 10,
    parameter int    RDATA_WIDTH = 18,
    parameter string REGMODE     = "reg",
    parameter int    RESP_DEPTH  = 4
) (
    input  logic                   rd_clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [RADDR_WIDTH-1:0] req_addr_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [RDATA_WIDTH-1:0] rsp_data_o,
    output logic [1:0]             rsp_err_o,
    output logic                   ram_rd_en_o,
    output logic                   ram_rd_clk_en_o,
    output logic                   ram_rd_out_clk_en_o,
    output logic [RADDR_WIDTH-1:0] ram_rd_addr_o,
    input  logic [RDATA_WIDTH-1:0] ram_rd_data_i,
    input  logic                   ram_one_err_i,
    input  logic                   ram_two_err_i,
    output logic [15:0]            rsp_cnt_o
);

    localparam bit IS_NOREG = (REGMODE == PDP_REGMODE_NOREG);
    localparam int LAT      = pdp_latency(IS_NOREG);
    localparam int PTR_W    = pdp_clog2(RESP_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int FIFO_W   = RDATA_WIDTH + 2;

    logic [LAT-1:0]    infl_q, infl_d;
    logic              ready_en_q;
    logic [15:0]       rsp_cnt_q, rsp_cnt_d;
    logic [CNT_W-1:0]  fifo_count, infl_count;
    logic [CNT_W:0]    outstanding;
    logic              accept, push, pop, fifo_empty;
    logic [FIFO_W-1:0] fifo_head;

    always_comb begin
        infl_count = '0;
        for (int i = 0; i < LAT; i++) begin
            infl_count = infl_count + CNT_W'(infl_q[i]);
        end
    end

    // Credit counts both buffered and in-flight reads, so the FIFO can never overflow
    // and ready never looks at rsp_ready_i.
    assign outstanding = {1'b0, fifo_count} + {1'b0, infl_count};
    assign req_ready_o = ready_en_q && (outstanding < (CNT_W + 1)'(RESP_DEPTH));
    assign accept      = req_valid_i && req_ready_o;

    assign ram_rd_en_o         = accept;
    assign ram_rd_addr_o       = req_addr_i;
    assign ram_rd_clk_en_o     = IS_NOREG ? accept : (accept | infl_q[0]);
    assign ram_rd_out_clk_en_o = accept | infl_q[0];

    assign infl_d    = (infl_q << 1) | LAT'(accept);
    assign push      = infl_q[LAT-1];
    assign pop       = rsp_valid_o && rsp_ready_i;
    assign rsp_cnt_d = rsp_cnt_q + 16'(pop);

    always_ff @(posedge rd_clk_i or posedge rst_i) begin
        if (rst_i) begin
            infl_q     <= '0;
            ready_en_q <= 1'b0;
            rsp_cnt_q  <= '0;
        end else begin
            infl_q     <= infl_d;
            ready_en_q <= 1'b1;
            rsp_cnt_q  <= rsp_cnt_d;
        end
    end

    pdp_rsp_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (RESP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (rd_clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i ({ram_two_err_i, ram_one_err_i, ram_rd_data_i}),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Head is masked while empty so stale storage never shows on the response port.
    assign rsp_valid_o = !fifo_empty;
    assign rsp_data_o  = rsp_valid_o ? fifo_head[RDATA_WIDTH-1:0] : '0;
    assign rsp_err_o   = rsp_valid_o ? fifo_head[FIFO_W-1 -: 2] : 2'b00;
    assign rsp_cnt_o   = rsp_cnt_q;

endmodule
